// File: rtl/scpad_be_dram_wr_packer_pkg.sv
// ----------------------------------------------------------------------------
// scpad_be_dram_wr_packer_pkg
// Shared scratchpad types and constants used by the backend DRAM write packer.
//   - Geometry of a scratchpad row and of a DRAM write beat.
//   - dram_write_req_t: one beat issued to the DRAM controller write port.
//   - wr_pack_state_t: packer FSM states.
//   - beat_mask(): per-element valid mask of one beat of a partial row.
// ----------------------------------------------------------------------------
package scpad_be_dram_wr_packer_pkg;

  localparam int NUM_COLS          = 32;
  localparam int ELEM_BITS         = 16;
  localparam int MAX_DRAM_BUS_BITS = 64;
  localparam int DRAM_ADDR_WIDTH   = 32;
  localparam int MAX_DIM_WIDTH     = $clog2(NUM_COLS);

  localparam int BEAT_ELEMS      = MAX_DRAM_BUS_BITS / ELEM_BITS;
  localparam int BEAT_BYTES      = MAX_DRAM_BUS_BITS / 8;
  localparam int BEATS_PER_ROW   = NUM_COLS / BEAT_ELEMS;
  localparam int BEAT_IDX_WIDTH  = $clog2(BEATS_PER_ROW);
  localparam int BEAT_ELEM_SHIFT = $clog2(BEAT_ELEMS);
  localparam int BEAT_BYTE_SHIFT = $clog2(BEAT_BYTES);

  typedef logic [NUM_COLS*ELEM_BITS-1:0] scpad_data_t;

  // Same bits as scpad_data_t, viewed as an array of DRAM beats (beat 0 in LSBs).
  typedef logic [BEATS_PER_ROW-1:0][MAX_DRAM_BUS_BITS-1:0] row_beats_t;

  typedef struct packed {
    logic                         valid;
    logic [DRAM_ADDR_WIDTH-1:0]   dram_addr;
    logic [MAX_DRAM_BUS_BITS-1:0] wdata;
    logic [BEAT_ELEMS-1:0]        dram_vector_mask;
  } dram_write_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wr_pack_state_t;

  // Element j of beat k is live when its column index 4k+j is within the row.
  function automatic logic [BEAT_ELEMS-1:0] beat_mask(
    input logic [BEAT_IDX_WIDTH-1:0] k,
    input logic [MAX_DIM_WIDTH-1:0]  num_cols_m1
  );
    logic [MAX_DIM_WIDTH-1:0] idx;
    beat_mask = '0;
    for (int j = 0; j < BEAT_ELEMS; j++) begin
      idx          = {k, BEAT_ELEM_SHIFT'(j)};
      beat_mask[j] = (idx <= num_cols_m1);
    end
  endfunction

endpackage

// File: rtl/scpad_be_dram_wr_packer.sv
// ----------------------------------------------------------------------------
// scpad_be_dram_wr_packer
// Takes one scratchpad row read out for a store-to-DRAM and issues it to the
// DRAM controller as a sequence of MAX_DRAM_BUS_BITS-wide write beats, with a
// per-element mask covering the tail of a partial row. One row in flight.
// Ports:
//   CLK, nRST      : clock, synchronous active-low reset
//   row_valid/ready: row offer handshake (ready only while idle)
//   row_data       : row contents, element 0 in the LSBs
//   row_dram_addr  : beat-aligned DRAM byte address of element 0
//   row_num_cols   : number of valid columns minus one
//   wr_req/wr_ready: write beat to the DRAM controller and its acceptance
//   busy           : a row is being sent
//   row_done       : one-cycle pulse after the last beat is accepted
// All outputs are decoded only from registered state.
// ----------------------------------------------------------------------------
module scpad_be_dram_wr_packer
  import scpad_be_dram_wr_packer_pkg::*;
(
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  scpad_data_t                row_data,
  input  logic [DRAM_ADDR_WIDTH-1:0] row_dram_addr,
  input  logic [MAX_DIM_WIDTH-1:0]   row_num_cols,
  output dram_write_req_t            wr_req,
  input  logic                       wr_ready,
  output logic                       busy,
  output logic                       row_done
);

  wr_pack_state_t             state_q, state_d;
  row_beats_t                 row_q, row_d;
  logic [DRAM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [MAX_DIM_WIDTH-1:0]   num_cols_m1_q, num_cols_m1_d;
  logic [BEAT_IDX_WIDTH-1:0]  k_q, k_d;
  logic                       row_done_q, row_done_d;

  logic [BEAT_IDX_WIDTH-1:0]  last_beat;
  logic [DRAM_ADDR_WIDTH-1:0] beat_offset;

  // Last beat holds column num_cols_m1; byte offset of beat k is k*BEAT_BYTES.
  always_comb begin
    last_beat   = num_cols_m1_q[MAX_DIM_WIDTH-1:BEAT_ELEM_SHIFT];
    beat_offset = {{(DRAM_ADDR_WIDTH-BEAT_IDX_WIDTH-BEAT_BYTE_SHIFT){1'b0}},
                   k_q, {BEAT_BYTE_SHIFT{1'b0}}};
  end

  // Next-state logic: latch a row in IDLE, step through its beats in SEND.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    base_d        = base_q;
    num_cols_m1_d = num_cols_m1_q;
    k_d           = k_q;
    row_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (row_valid) begin
          state_d       = SEND;
          row_d         = row_data;
          base_d        = row_dram_addr;
          num_cols_m1_d = row_num_cols;
          k_d           = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (wr_ready) begin
          if (k_q == last_beat) begin
            state_d    = IDLE;
            k_d        = '0;
            row_done_d = 1'b1;
          end else begin
            k_d = k_q + BEAT_IDX_WIDTH'(1);
          end
        end else begin
          k_d = k_q;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // State registers; reset aborts any row in flight without a done pulse.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= IDLE;
      row_q         <= '0;
      base_q        <= '0;
      num_cols_m1_q <= '0;
      k_q           <= '0;
      row_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      base_q        <= base_d;
      num_cols_m1_q <= num_cols_m1_d;
      k_q           <= k_d;
      row_done_q    <= row_done_d;
    end
  end

  // Beat k is a pure function of held registers, so it stays stable under backpressure.
  always_comb begin
    wr_req = '0;
    if (state_q == SEND) begin
      wr_req.valid            = 1'b1;
      wr_req.wdata            = row_q[k_q];
      wr_req.dram_addr        = base_q + beat_offset;
      wr_req.dram_vector_mask = beat_mask(k_q, num_cols_m1_q);
    end else begin
      wr_req.valid = 1'b0;
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    row_ready = (state_q == IDLE);
    busy      = (state_q == SEND);
    row_done  = row_done_q;
  end

endmodule

// File: tb/tb_scpad_be_dram_wr_packer.sv
// ----------------------------------------------------------------------------
// tb_scpad_be_dram_wr_packer
// Self-checking bench for scpad_be_dram_wr_packer: a table of directed vectors
// with hand-computed expectations, hand-written multi-cycle sequences, and
// random traffic. A reference model keeps the beats still owed to DRAM as a
// queue built from the row/address/column-count rules.
// ----------------------------------------------------------------------------
module tb_scpad_be_dram_wr_packer;
  import scpad_be_dram_wr_packer_pkg::*;

  logic            CLK;
  logic            nRST;
  logic            row_valid;
  logic            row_ready;
  scpad_data_t     row_data;
  logic [31:0]     row_dram_addr;
  logic [4:0]      row_num_cols;
  dram_write_req_t wr_req;
  logic            wr_ready;
  logic            busy;
  logic            row_done;

  scpad_be_dram_wr_packer dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_dram_addr (row_dram_addr),
    .row_num_cols  (row_num_cols),
    .wr_req        (wr_req),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .row_done      (row_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  mask;
  } beat_t;

  beat_t m_q[$];
  bit    m_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: compare outputs with the model, drive inputs,
  // advance the model by one clock, return at the next negedge.
  task automatic cycle(input logic nrst_i, input logic rv_i, input scpad_data_t d_i,
                       input logic [31:0] a_i, input logic [4:0] nc_i, input logic wr_i);
    bit    nd;
    beat_t b;
    int    idx;
    check("model_valid", wr_req.valid, m_q.size() != 0);
    check("model_busy", busy, m_q.size() != 0);
    check("model_ready", row_ready, m_q.size() == 0);
    check("model_done", row_done, m_done);
    if (m_q.size() != 0) begin
      check("model_addr", wr_req.dram_addr, m_q[0].addr);
      check("model_wdata", wr_req.wdata, m_q[0].data);
      check("model_mask", wr_req.dram_vector_mask, m_q[0].mask);
    end
    nRST          = nrst_i;
    row_valid     = rv_i;
    row_data      = d_i;
    row_dram_addr = a_i;
    row_num_cols  = nc_i;
    wr_ready      = wr_i;
    if (!nrst_i) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      nd = 1'b0;
      if (m_q.size() != 0) begin
        if (wr_i) begin
          if (m_q.size() == 1) nd = 1'b1;
          void'(m_q.pop_front());
        end
      end else if (rv_i) begin
        for (int k = 0; k <= int'(nc_i) / 4; k++) begin
          b.addr = a_i + 32'(k * 8);
          for (int j = 0; j < 4; j++) begin
            idx = 4 * k + j;
            b.data[16*j +: 16] = d_i[16*idx +: 16];
            b.mask[j] = (idx <= int'(nc_i));
          end
          m_q.push_back(b);
        end
      end
      m_done = nd;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic scpad_data_t rnd_row();
    scpad_data_t r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [4:0]  nc;
    logic        wrdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [63:0] e_wdata;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic rv, input logic [31:0] addr, input logic [4:0] nc,
                              input logic wrdy, input logic ev, input logic [31:0] ea,
                              input logic [3:0] em, input logic [63:0] ew,
                              input logic ed, input logic er);
    vec_t v;
    v.rv = rv; v.addr = addr; v.nc = nc; v.wrdy = wrdy;
    v.e_valid = ev; v.e_addr = ea; v.e_mask = em; v.e_wdata = ew;
    v.e_done = ed; v.e_ready = er;
    return v;
  endfunction

  scpad_data_t tbl_row;
  scpad_data_t row_a;
  scpad_data_t row_b;
  logic [63:0] zero64;
  logic [63:0] seq_lo;
  logic [63:0] seq_hi;

  initial begin
    zero64 = 64'h0;
    seq_lo = 64'h0003_0002_0001_0000;
    seq_hi = 64'h0000_0000_0005_0004;
    tbl_row = '0;
    for (int i = 0; i < 6; i++) tbl_row[16*i +: 16] = 16'(i);

    // Partial row: 6 columns at 0x2000.
    tbl[0]  = mk(1'b1, 32'h2000,     5'd5,  1'b1, 1'b0, 32'h0,        4'h0, zero64, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 32'h2000,     4'hF, seq_lo, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 32'h2008,     4'h3, seq_hi, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b0, 32'h0,        4'h0, zero64, 1'b1, 1'b1);
    tbl[4]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b0, 32'h0,        4'h0, zero64, 1'b0, 1'b1);
    // Address wrap: 16 columns at 0xFFFF_FFF8, first beat stalled one cycle.
    tbl[5]  = mk(1'b1, 32'hFFFF_FFF8, 5'd15, 1'b1, 1'b0, 32'h0,        4'h0, zero64, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 32'hFFFF_FFF8, 4'hF, seq_lo, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 32'hFFFF_FFF8, 4'hF, seq_lo, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 32'h0,        4'hF, seq_hi, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 32'h8,        4'hF, zero64, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 32'h10,       4'hF, zero64, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0,        4'h0, zero64, 1'b1, 1'b1);

    nRST = 1'b0; row_valid = 1'b0; row_data = '0; row_dram_addr = '0;
    row_num_cols = '0; wr_ready = 1'b0;
    @(negedge CLK);
    cycle(1'b0, 1'b1, '0, 32'h0, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, '0, 32'h0, 5'd0, 1'b0);

    // Reset values.
    check("reset_wr_req", 64'(wr_req), 64'h0);
    check("reset_wr_req_hi", 64'(wr_req >> 64), 64'h0);
    check("reset_ready", row_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", row_done, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      check("tbl_valid", wr_req.valid, tbl[i].e_valid);
      check("tbl_ready", row_ready, tbl[i].e_ready);
      check("tbl_done", row_done, tbl[i].e_done);
      if (tbl[i].e_valid) begin
        check("tbl_addr", wr_req.dram_addr, tbl[i].e_addr);
        check("tbl_mask", wr_req.dram_vector_mask, tbl[i].e_mask);
        check("tbl_wdata", wr_req.wdata, tbl[i].e_wdata);
      end
      cycle(1'b1, tbl[i].rv, tbl_row, tbl[i].addr, tbl[i].nc, tbl[i].wrdy);
    end

    // Full 32-column row at 0x1000, wr_ready held high: beats at cycles 1-8, done at 9.
    row_a = rnd_row();
    cycle(1'b1, 1'b1, row_a, 32'h1000, 5'd31, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      check("full_addr", wr_req.dram_addr, 32'h1000 + 32'((c - 1) * 8));
      check("full_mask", wr_req.dram_vector_mask, 4'hF);
      cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    end
    check("full_done_c9", row_done, 1'b1);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);

    // Backpressure: beat 2 stalled for 3 cycles; model checks hold and ordering.
    row_a = rnd_row();
    cycle(1'b1, 1'b1, row_a, 32'h8000, 5'd31, 1'b1);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b0);
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    check("bp_done_c12", row_done, 1'b1);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);

    // row_valid held during SEND: second row taken only in the row_done cycle.
    row_a = rnd_row();
    row_b = rnd_row();
    cycle(1'b1, 1'b1, row_a, 32'h5000, 5'd7, 1'b1);
    cycle(1'b1, 1'b1, row_b, 32'h6000, 5'd0, 1'b1);
    cycle(1'b1, 1'b1, row_b, 32'h6000, 5'd0, 1'b1);
    check("hold_done_and_ready", {row_done, row_ready}, 2'b11);
    cycle(1'b1, 1'b1, row_b, 32'h6000, 5'd0, 1'b1);
    check("one_col_mask", wr_req.dram_vector_mask, 4'h1);
    check("one_col_addr", wr_req.dram_addr, 32'h6000);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);

    // Reset during beat 3 of 8, then a fresh row.
    row_a = rnd_row();
    cycle(1'b1, 1'b1, row_a, 32'h3000, 5'd31, 1'b1);
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    check("pre_rst_beat3_addr", wr_req.dram_addr, 32'h3018);
    cycle(1'b0, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    check("post_rst_valid", wr_req.valid, 1'b0);
    check("post_rst_ready", row_ready, 1'b1);
    check("post_rst_done", row_done, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);
    row_b = rnd_row();
    cycle(1'b1, 1'b1, row_b, 32'h4000, 5'd31, 1'b1);
    check("fresh_beat0_addr", wr_req.dram_addr, 32'h4000);
    for (int c = 0; c < 9; c++) cycle(1'b1, 1'b0, '0, 32'h0, 5'd0, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 59) != 0, $urandom_range(0, 2) != 0, rnd_row(),
            $urandom() & 32'hFFFF_FFF8, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scpad_be_dram_wr_packer.md
# scpad_be_dram_wr_packer

Backend write-path stage of the scratchpad. It consumes one full scratchpad row (`scpad_data_t`) that the backend has read out for a store-to-DRAM. It slices the row into `MAX_DRAM_BUS_BITS`-wide beats and issues them to the DRAM controller as `dram_write_req_t`, with a per-element `dram_vector_mask` covering partial rows. It sits between the backend SRAM read return and the DRAM controller write port, and supports one row in flight.

## Interface
Parameters (the package values are authoritative; these are the defaults):
- `NUM_COLS`, 32, elements per scratchpad row
- `ELEM_BITS`, 16, bits per element
- `MAX_DRAM_BUS_BITS`, 64, DRAM write beat width
- `DRAM_ADDR_WIDTH`, 32, DRAM byte-address width
- `MAX_DIM_WIDTH`, $clog2(NUM_COLS), width of the column-count field

Ports:
- `CLK` in 1: single clock, all logic on posedge
- `nRST` in 1: reset, synchronous, active-low
- `row_valid` in 1: the row offer is valid
- `row_ready` out 1: the block accepts a row; high only in IDLE
- `row_data` in `scpad_data_t`: row contents, element 0 in the LSBs
- `row_dram_addr` in `DRAM_ADDR_WIDTH`: DRAM byte address of element 0; must be `BEAT_BYTES`-aligned
- `row_num_cols` in `MAX_DIM_WIDTH`: number of valid columns minus 1 (0 means 1 column, 31 means 32 columns)
- `wr_req` out `dram_write_req_t`: beat to DRAM, with `valid`, `wdata`, `dram_addr` and `dram_vector_mask` fields
- `wr_ready` in 1: the DRAM controller accepts the beat
- `busy` out 1: high while in SEND
- `row_done` out 1: one-cycle pulse after the last beat of a row is accepted

## Operation
Derived constants:
- `BEAT_ELEMS` = MAX_DRAM_BUS_BITS/ELEM_BITS = 4
- `BEAT_BYTES` = 8
- `BEATS_PER_ROW` = NUM_COLS/BEAT_ELEMS = 8

States:
- IDLE: `row_ready`=1. A row is accepted when `row_valid && row_ready`. On acceptance the block latches data, address and `row_num_cols`, clears beat index k, and moves to SEND.
- SEND: `wr_req.valid`=1 and `busy`=1.
  - Beat k contents:
    - `wdata` = elements 4k..4k+3, with element 4k in bits [15:0].
    - `dram_addr` = base + k*BEAT_BYTES, computed modulo 2^DRAM_ADDR_WIDTH (wraps silently).
    - `dram_vector_mask[j]` = ((4k+j) <= num_cols_m1).
  - Last beat index = num_cols_m1 >> 2. Beats beyond it are never issued; a mask of all zeros is never issued.
  - On `wr_ready` with k < last: k increments.
  - On `wr_ready` with k == last: go to IDLE and register `row_done`=1 for the next cycle.

Handshake and input rules:
- Once `wr_req.valid` rises, it and all `wr_req` fields are held stable until `wr_ready`; the block never withdraws a beat.
- `row_valid` in SEND is ignored; there is no row acceptance.
- `row_data` is sampled only on acceptance, so the upstream may change it afterwards.
- Unused `dram_req`-style fields are not produced; `wr_req.wdata` comes from the latched row only.

## Timing
Reset values:
- State IDLE, k=0.
- `row_ready`=1, `busy`=0, `row_done`=0.
- `wr_req` all zeros, including `valid`=0.

Reset behaviour:
- Reset is synchronous, so `nRST` low at a posedge aborts any row immediately.
- No further beats are issued and no `row_done` pulse follows.

Latency and throughput:
- Row accepted at cycle 0; beat 0 is valid at cycle 1.
- With `wr_ready` held high, one beat is issued per cycle. A 32-column row issues beats at cycles 1–8.
- `row_done` and `row_ready` are high at cycle 9, so the next row can be accepted at cycle 9. Sustained rate is BEATS+1 cycles per row.

Boundary conditions:
- `wr_ready` asserted while `valid`=0 has no effect.
- A 1-column row produces one beat with mask 0001.
- `row_done` is high only in IDLE; it may coincide with a new row being accepted.

## Structure
Add to the scratchpad package:
- constants `BEAT_ELEMS`, `BEAT_BYTES`, `BEATS_PER_ROW`, `BEAT_IDX_WIDTH`
- typedef `wr_pack_state_t` enum {IDLE, SEND}
- `dram_write_req_t` already lives in the package and is reused unchanged

Implementation:
- Single module; no sub-module.
- Beat slicing is an indexed part-select on the latched row, and the mask is a 4-bit compare.
- Registers: the row buffer (NUM_COLS*ELEM_BITS bits), base address, `num_cols_m1`, k, state, `row_done`.

## Test plan
- Full row, 32 cols (`row_num_cols`=31), base 0x1000, `wr_ready`=1 → 8 beats at cycles 1–8, addresses 0x1000..0x1038, every mask 1111, `row_done` at cycle 9.
- Partial row, 6 cols (`row_num_cols`=5), data elements 0x0000..0x0005 → 2 beats: mask 1111 with wdata 0x0003_0002_0001_0000, then mask 0011 with wdata 0x0000_0000_0005_0004.
- Backpressure: `wr_ready` low for 3 cycles on beat 2 → beat 2 fields held bit-identical, no skipped or duplicated beat, `row_done` delayed by 3 cycles.
- Address wrap: base 0xFFFF_FFF8 with 16 cols → beat addresses 0xFFFF_FFF8, 0x0, 0x8, 0x10.
- `row_valid` asserted during SEND → `row_ready`=0 and the row is not taken; it is accepted in the `row_done` cycle.
- `nRST` low during beat 3 of 8 → next cycle `wr_req.valid`=0, `row_ready`=1, no `row_done`; a fresh row afterwards starts at beat 0.
